l2_msg_sched: RTL and testbench
===============================

# l2_msg_sched

Input scheduler and response sequencer for the single-line PMESH L2 message datapath. It arbitrates the request channel (msg1) and the response channel (msg3) into one current-message register set consumed by the L2 processing logic. It then drives the outgoing msg2 channel, including its clear on handshake. msg3 has priority, with a bounded starvation guard so msg1 always makes progress.

## Interface
Parameters:
- TYPE_W, 8, message type width
- SRC_W, 6, source id width
- TAG_W, 26, tag width
- DATA_W, 64, data width
- STARVE_LIMIT, 4, consecutive msg3 grants tolerated while msg1 waits (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- msg1_valid / msg1_ready  in / out  1 / 1  request channel handshake
- msg1_type, msg1_source, msg1_tag, msg1_data  in  TYPE_W, SRC_W, TAG_W, DATA_W  request payload
- msg3_valid / msg3_ready  in / out  1 / 1  response channel handshake
- msg3_type, msg3_source, msg3_tag, msg3_data  in  same widths  response payload
- cur_valid  out  1  current message held for the processor
- cur_chan  out  1  0 = from msg1, 1 = from msg3
- cur_msg_type, cur_msg_source, cur_msg_tag, cur_msg_data  out  as payload  latched message
- proc_done  in  1  processor finished the current message (sampled in BUSY only)
- proc_msg2_req  in  1  with proc_done: emit msg2
- proc_msg2_type  in  TYPE_W  msg2 type to emit
- msg2_valid  out  1  outgoing message valid
- msg2_type  out  TYPE_W  outgoing message type
- msg2_ready  in  1  downstream accept

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE grant (combinational):
  - grant3 = msg3_valid && (!msg1_valid || starve_cnt < STARVE_LIMIT)
  - grant1 = msg1_valid && !grant3
- Ready outputs:
  - msg3_ready = (state==IDLE) && grant3
  - msg1_ready = (state==IDLE) && grant1
  - Both are 0 in BUSY and RESP.
- Transfer on valid&&ready: latch the payload into cur_msg_*, set cur_chan, set cur_valid=1, and go to BUSY.
- Starvation counter (saturating at STARVE_LIMIT):
  - +1 on a msg3 transfer while msg1_valid=1.
  - Cleared on a msg1 transfer.
  - Unchanged otherwise.
- BUSY:
  - proc_done=0: hold everything.
  - proc_done=1: clear cur_valid (cur_msg_* keep their values).
  - If proc_msg2_req=1 as well: msg2_type<=proc_msg2_type, msg2_valid<=1, go to RESP. Otherwise go to IDLE.
- RESP:
  - msg2_ready=1: msg2_valid<=0 (msg2 clear), msg2_type holds, go to IDLE.
  - Otherwise hold.
- proc_done, proc_msg2_req are ignored outside BUSY. msg2_ready is ignored outside RESP.
- Payload inputs are don't-care when the corresponding valid=0. No combinational path from any payload input to any output.

## Timing
- Reset (async assert, sync-safe deassert) clears: state=IDLE, cur_valid=0, cur_chan=0, cur_msg_*=0, msg2_valid=0, msg2_type=0, starve_cnt=0, msgX_ready=0.
- Reset mid-operation drops the in-flight message and any pending msg2.
- Acceptance to cur_valid: 1 cycle (registered).
- proc_done to next ready: 1 cycle. Minimum throughput is 1 message per 2 cycles without a response, and 3 cycles with a response and immediate msg2_ready.
- msg2_valid rises the cycle after proc_done and is held until the msg2_ready cycle. It falls the cycle after the handshake.
- Both valids high in IDLE with starve_cnt==STARVE_LIMIT: msg1 wins, and the counter clears.
- Valid deasserted before ready: no transfer and no counter change (grant is recomputed every cycle).

## Structure
- Package l2_msg_pkg:
  - Width constants TYPE_W, SRC_W, TAG_W, DATA_W.
  - State enum {IDLE, BUSY, RESP}.
  - Packed struct l2_msg_t {type, source, tag, data}.
  - Channel id constants CH_MSG1=0, CH_MSG3=1.
- Sub-module l2_starve_ctr holds the saturating counter. Inputs: inc, clr, limit compare. Output: starved.

## Test plan
- Reset, then msg1_valid=1 type=0x10 tag=0x123: msg1_ready=1 cycle 0, cur_valid=1 cycle 1 with cur_chan=0, cur_msg_tag=0x123. proc_done=1, proc_msg2_req=0: cur_valid=0, msg1_ready=1 next cycle.
- msg1 and msg3 valid together continuously, STARVE_LIMIT=4, proc_done each BUSY cycle: grant order 3,3,3,3,1,3,3,3,3,1.
- proc_done with proc_msg2_req=1, type=0x2A, msg2_ready=0 for 3 cycles then 1: msg2_valid=1, msg2_type=0x2A held 4 cycles, msg2_valid=0 after the handshake, both readies low throughout RESP.
- Reset asserted in BUSY and again in RESP: all outputs zero immediately (async), state IDLE after release, no msg2 emitted.
- proc_done pulses in IDLE and msg2_ready pulses in BUSY: no state or output change.
- msg3_valid pulsed for one cycle while in BUSY then dropped: no transfer, starve_cnt unchanged.

Source files
------------

// File: rtl/l2_msg_pkg.sv
// Shared widths, FSM states, message layout and channel ids for the L2 message scheduler.
package l2_msg_pkg;

    localparam int unsigned TYPE_W = 8;
    localparam int unsigned SRC_W  = 6;
    localparam int unsigned TAG_W  = 26;
    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef struct packed {
        logic [TYPE_W-1:0] msg_type;
        logic [SRC_W-1:0]  source;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } l2_msg_t;

    localparam logic CH_MSG1 = 1'b0;
    localparam logic CH_MSG3 = 1'b1;

endpackage

// File: rtl/l2_msg_sched_starve_ctr.sv
// Saturating count of msg3 grants taken while msg1 was waiting.
module l2_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic starved_o
);

    localparam int unsigned       CW  = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]     LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign starved_o = (cnt_q >= LIM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !starved_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/l2_msg_sched.sv
// Arbitrates msg1/msg3 into the current-message registers and sequences the msg2 response.
module l2_msg_sched
    import l2_msg_pkg::*;
#(
    parameter int unsigned TYPE_W       = l2_msg_pkg::TYPE_W,
    parameter int unsigned SRC_W        = l2_msg_pkg::SRC_W,
    parameter int unsigned TAG_W        = l2_msg_pkg::TAG_W,
    parameter int unsigned DATA_W       = l2_msg_pkg::DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msg1_valid_i,
    output logic              msg1_ready_o,
    input  logic [TYPE_W-1:0] msg1_type_i,
    input  logic [SRC_W-1:0]  msg1_source_i,
    input  logic [TAG_W-1:0]  msg1_tag_i,
    input  logic [DATA_W-1:0] msg1_data_i,
    input  logic              msg3_valid_i,
    output logic              msg3_ready_o,
    input  logic [TYPE_W-1:0] msg3_type_i,
    input  logic [SRC_W-1:0]  msg3_source_i,
    input  logic [TAG_W-1:0]  msg3_tag_i,
    input  logic [DATA_W-1:0] msg3_data_i,
    output logic              cur_valid_o,
    output logic              cur_chan_o,
    output logic [TYPE_W-1:0] cur_msg_type_o,
    output logic [SRC_W-1:0]  cur_msg_source_o,
    output logic [TAG_W-1:0]  cur_msg_tag_o,
    output logic [DATA_W-1:0] cur_msg_data_o,
    input  logic              proc_done_i,
    input  logic              proc_msg2_req_i,
    input  logic [TYPE_W-1:0] proc_msg2_type_i,
    output logic              msg2_valid_o,
    output logic [TYPE_W-1:0] msg2_type_o,
    input  logic              msg2_ready_i
);

    // Local layout so overridden widths stay consistent with the ports.
    typedef struct packed {
        logic [TYPE_W-1:0] msg_type;
        logic [SRC_W-1:0]  source;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } msg_t;

    state_e            state_q, state_d;
    msg_t              cur_q, cur_d;
    logic              cur_valid_q, cur_valid_d;
    logic              cur_chan_q, cur_chan_d;
    logic              msg2_valid_q, msg2_valid_d;
    logic [TYPE_W-1:0] msg2_type_q, msg2_type_d;
    logic              grant1, grant3, starved, starve_inc, starve_clr;

    l2_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (starve_inc),
        .clr_i     (starve_clr),
        .starved_o (starved)
    );

    assign grant3 = msg3_valid_i && (!msg1_valid_i || !starved);
    assign grant1 = msg1_valid_i && !grant3;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        cur_valid_d  = cur_valid_q;
        cur_chan_d   = cur_chan_q;
        msg2_valid_d = msg2_valid_q;
        msg2_type_d  = msg2_type_q;
        msg1_ready_o = 1'b0;
        msg3_ready_o = 1'b0;
        starve_inc   = 1'b0;
        starve_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                msg3_ready_o = grant3;
                msg1_ready_o = grant1;
                if (grant3) begin
                    cur_d       = {msg3_type_i, msg3_source_i, msg3_tag_i, msg3_data_i};
                    cur_chan_d  = CH_MSG3;
                    cur_valid_d = 1'b1;
                    starve_inc  = msg1_valid_i;
                    state_d     = BUSY;
                end else if (grant1) begin
                    cur_d       = {msg1_type_i, msg1_source_i, msg1_tag_i, msg1_data_i};
                    cur_chan_d  = CH_MSG1;
                    cur_valid_d = 1'b1;
                    starve_clr  = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (proc_done_i) begin
                    cur_valid_d = 1'b0;
                    if (proc_msg2_req_i) begin
                        msg2_valid_d = 1'b1;
                        msg2_type_d  = proc_msg2_type_i;
                        state_d      = RESP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (msg2_ready_i) begin
                    msg2_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            cur_valid_q  <= 1'b0;
            cur_chan_q   <= 1'b0;
            msg2_valid_q <= 1'b0;
            msg2_type_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            cur_valid_q  <= cur_valid_d;
            cur_chan_q   <= cur_chan_d;
            msg2_valid_q <= msg2_valid_d;
            msg2_type_q  <= msg2_type_d;
        end
    end

    assign cur_valid_o      = cur_valid_q;
    assign cur_chan_o       = cur_chan_q;
    assign cur_msg_type_o   = cur_q.msg_type;
    assign cur_msg_source_o = cur_q.source;
    assign cur_msg_tag_o    = cur_q.tag;
    assign cur_msg_data_o   = cur_q.data;
    assign msg2_valid_o     = msg2_valid_q;
    assign msg2_type_o      = msg2_type_q;

endmodule

// File: tb/tb_l2_msg_sched.sv
// Scoreboard bench for l2_msg_sched: directed stimulus, monitor-side comparison of latched messages and msg2 handshakes.
module tb_l2_msg_sched;

    localparam int unsigned TW = 8;
    localparam int unsigned SW = 6;
    localparam int unsigned GW = 26;
    localparam int unsigned DW = 64;
    localparam int unsigned PW = TW + SW + GW + DW;

    logic          clk;
    logic          rst_n;
    logic          msg1_valid, msg1_ready, msg3_valid, msg3_ready;
    logic [TW-1:0] msg1_type, msg3_type;
    logic [SW-1:0] msg1_source, msg3_source;
    logic [GW-1:0] msg1_tag, msg3_tag;
    logic [DW-1:0] msg1_data, msg3_data;
    logic          cur_valid, cur_chan;
    logic [TW-1:0] cur_type;
    logic [SW-1:0] cur_source;
    logic [GW-1:0] cur_tag;
    logic [DW-1:0] cur_data;
    logic          proc_done, proc_msg2_req;
    logic [TW-1:0] proc_msg2_type;
    logic          msg2_valid, msg2_ready;
    logic [TW-1:0] msg2_type;

    l2_msg_sched #(
        .TYPE_W       (TW),
        .SRC_W        (SW),
        .TAG_W        (GW),
        .DATA_W       (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .msg1_valid_i     (msg1_valid),
        .msg1_ready_o     (msg1_ready),
        .msg1_type_i      (msg1_type),
        .msg1_source_i    (msg1_source),
        .msg1_tag_i       (msg1_tag),
        .msg1_data_i      (msg1_data),
        .msg3_valid_i     (msg3_valid),
        .msg3_ready_o     (msg3_ready),
        .msg3_type_i      (msg3_type),
        .msg3_source_i    (msg3_source),
        .msg3_tag_i       (msg3_tag),
        .msg3_data_i      (msg3_data),
        .cur_valid_o      (cur_valid),
        .cur_chan_o       (cur_chan),
        .cur_msg_type_o   (cur_type),
        .cur_msg_source_o (cur_source),
        .cur_msg_tag_o    (cur_tag),
        .cur_msg_data_o   (cur_data),
        .proc_done_i      (proc_done),
        .proc_msg2_req_i  (proc_msg2_req),
        .proc_msg2_type_i (proc_msg2_type),
        .msg2_valid_o     (msg2_valid),
        .msg2_type_o      (msg2_type),
        .msg2_ready_i     (msg2_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int misc    = 0;

    logic [PW:0]   exp_cur[$];
    logic [TW-1:0] exp_msg2[$];
    logic          cur_valid_prev = 1'b0;

    localparam logic [PW-1:0] PL1 = {8'h01, 6'h01, 26'h0000111, 64'h1111_1111_1111_1111};
    localparam logic [PW-1:0] PL3 = {8'h03, 6'h03, 26'h0000333, 64'h3333_3333_3333_3333};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a new latched message or a msg2 handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        logic [PW:0]   e;
        logic [TW-1:0] t;
        if (rst_n) begin
            if (cur_valid && !cur_valid_prev) begin
                if (exp_cur.size() == 0) begin
                    vectors++;
                    misc++;
                    $display("FAIL cur_unexpected: got chan %0d tag %0h expected no message", cur_chan, cur_tag);
                end else begin
                    e = exp_cur.pop_front();
                    chk("cur_msg", {cur_chan, cur_type, cur_source, cur_tag, cur_data}, e);
                end
            end
            if (msg2_valid && msg2_ready) begin
                if (exp_msg2.size() == 0) begin
                    vectors++;
                    misc++;
                    $display("FAIL msg2_unexpected: got type %0h expected no msg2", msg2_type);
                end else begin
                    t = exp_msg2.pop_front();
                    chk("msg2_type", msg2_type, t);
                end
            end
        end
        cur_valid_prev = cur_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_zero(input string nm);
        chk({nm, "_cur_valid"}, cur_valid, 0);
        chk({nm, "_cur_chan"}, cur_chan, 0);
        chk({nm, "_cur_payload"}, {cur_type, cur_source, cur_tag, cur_data}, 0);
        chk({nm, "_msg2_valid"}, msg2_valid, 0);
        chk({nm, "_msg2_type"}, msg2_type, 0);
        chk({nm, "_readies"}, {msg1_ready, msg3_ready}, 0);
    endtask

    // Entry and exit at one time unit after a rising edge; DUT expected in IDLE on entry.
    task automatic send(input logic ch, input logic [PW-1:0] pl, output int waited);
        logic got;
        waited = 0;
        got    = 1'b0;
        exp_cur.push_back({ch, pl});
        if (ch) begin
            {msg3_type, msg3_source, msg3_tag, msg3_data} = pl;
            msg3_valid = 1'b1;
        end else begin
            {msg1_type, msg1_source, msg1_tag, msg1_data} = pl;
            msg1_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ch ? msg3_ready : msg1_ready) begin
                got = 1'b1;
                break;
            end
            step();
            waited++;
        end
        if (!got) begin
            vectors++;
            misc++;
            $display("FAIL send_timeout: got no ready after %0d cycles expected ready", waited);
        end
        step();
        msg1_valid = 1'b0;
        msg3_valid = 1'b0;
    endtask

    task automatic done(input logic req, input logic [TW-1:0] t);
        proc_done      = 1'b1;
        proc_msg2_req  = req;
        proc_msg2_type = t;
        step();
        proc_done      = 1'b0;
        proc_msg2_req  = 1'b0;
    endtask

    // Both channels held valid with the processor finishing every BUSY cycle.
    task automatic arb(input int n);
        {msg1_type, msg1_source, msg1_tag, msg1_data} = PL1;
        {msg3_type, msg3_source, msg3_tag, msg3_data} = PL3;
        msg1_valid    = 1'b1;
        msg3_valid    = 1'b1;
        proc_done     = 1'b1;
        proc_msg2_req = 1'b0;
        for (int i = 0; i < 2 * n - 1; i++) step();
        msg1_valid = 1'b0;
        msg3_valid = 1'b0;
        step();
        proc_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [PW-1:0] pl;
        logic order10[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b1;
        {msg1_valid, msg3_valid, proc_done, proc_msg2_req, msg2_ready} = '0;
        {msg1_type, msg1_source, msg1_tag, msg1_data} = '0;
        {msg3_type, msg3_source, msg3_tag, msg3_data} = '0;
        proc_msg2_type = '0;
        #2 rst_n = 1'b0;
        #1 reset_zero("rst0");
        repeat (2) step();
        rst_n = 1'b1;

        // Single msg1 transfer and release
        send(1'b0, {8'h10, 6'h05, 26'h0000123, 64'h0123_4567_89AB_CDEF}, w);
        chk("p1_ready_latency", w, 0);
        @(negedge clk);
        chk("p1_cur_valid", cur_valid, 1);
        chk("p1_busy_ready", msg1_ready, 0);
        step();
        done(1'b0, '0);
        @(negedge clk);
        chk("p1_cur_cleared", cur_valid, 0);
        chk("p1_tag_held", cur_tag, 26'h123);
        step();
        send(1'b0, {8'h11, 6'h06, 26'h0000124, 64'h0000_0000_0000_0042}, w);
        chk("p1_ready_after_done", w, 0);
        done(1'b0, '0);

        // Starvation guard ordering 3,3,3,3,1,3,3,3,3,1
        for (int i = 0; i < 10; i++) exp_cur.push_back(order10[i] ? {1'b1, PL3} : {1'b0, PL1});
        arb(10);

        // msg2 emission with delayed downstream accept
        send(1'b0, {8'h20, 6'h07, 26'h0000200, 64'h0000_0000_0000_2020}, w);
        exp_msg2.push_back(8'h2A);
        done(1'b1, 8'h2A);
        msg1_valid = 1'b1;
        msg3_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("resp_msg2_valid", msg2_valid, 1);
            chk("resp_msg2_type", msg2_type, 8'h2A);
            chk("resp_readies", {msg1_ready, msg3_ready}, 0);
            step();
        end
        msg2_ready = 1'b1;
        @(negedge clk);
        chk("resp_hs_valid", msg2_valid, 1);
        chk("resp_hs_readies", {msg1_ready, msg3_ready}, 0);
        step();
        msg2_ready = 1'b0;
        msg1_valid = 1'b0;
        msg3_valid = 1'b0;
        @(negedge clk);
        chk("resp_cleared", msg2_valid, 0);
        chk("resp_type_held", msg2_type, 8'h2A);
        chk("resp_no_xfer", cur_valid, 0);
        step();

        // Reset while BUSY
        send(1'b0, {8'h30, 6'h08, 26'h0000300, 64'h0000_0000_0000_3030}, w);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 reset_zero("rst_busy");
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy_after", {cur_valid, msg2_valid}, 0);
        step();

        // Reset while RESP: pending msg2 must vanish
        send(1'b0, {8'h31, 6'h09, 26'h0000301, 64'h0000_0000_0000_3131}, w);
        done(1'b1, 8'h33);
        @(negedge clk);
        chk("rst_resp_pre", msg2_valid, 1);
        #2 rst_n = 1'b0;
        #1 reset_zero("rst_resp");
        step();
        rst_n = 1'b1;
        msg2_ready = 1'b1;
        @(negedge clk);
        chk("rst_resp_no_msg2", msg2_valid, 0);
        step();
        msg2_ready = 1'b0;

        // Stray control pulses in the wrong states
        proc_done      = 1'b1;
        proc_msg2_req  = 1'b1;
        proc_msg2_type = 8'h55;
        step();
        proc_done     = 1'b0;
        proc_msg2_req = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", {cur_valid, msg2_valid, msg2_type}, 0);
        step();
        pl = {8'h40, 6'h0A, 26'h0000400, 64'h0000_0000_0000_4040};
        send(1'b0, pl, w);
        msg2_ready = 1'b1;
        step();
        msg2_ready = 1'b0;
        @(negedge clk);
        chk("busy_ready_ignored", {cur_valid, msg2_valid}, 2'b10);
        step();
        msg1_valid = 1'b1;
        msg3_valid = 1'b1;
        @(negedge clk);
        chk("busy_pulse_readies", {msg1_ready, msg3_ready}, 0);
        step();
        msg1_valid = 1'b0;
        msg3_valid = 1'b0;
        @(negedge clk);
        chk("busy_pulse_no_xfer", {cur_valid, cur_chan, cur_tag}, {1'b1, 1'b0, 26'h400});
        done(1'b0, '0);

        // Counter untouched by the pulse: full run of four msg3 before msg1
        for (int i = 0; i < 5; i++) exp_cur.push_back(order10[i] ? {1'b1, PL3} : {1'b0, PL1});
        arb(5);

        repeat (3) step();
        chk("exp_cur_drained", exp_cur.size(), 0);
        chk("exp_msg2_drained", exp_msg2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
